timing_sequencer: RTL and testbench

//  Parametrised T-state sequencer driving the random control block's timing

---
 rtl/timing_pkg.sv | 17 +
 rtl/edge_sync.sv | 34 +++
 rtl/timing_sequencer.sv | 102 ++++++++++
 tb/tb_timing_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared constants for the T-state sequencer: T-state indices and interrupt vector codes.
package timing_pkg;

    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;

    localparam logic [1:0] VEC_IRQ = 2'b00;
    localparam logic [1:0] VEC_NMI = 2'b01;
    localparam logic [1:0] VEC_RES = 2'b10;

    // One-hot encoding for T-state index idx (0 = T1).
    function automatic logic [31:0] t_onehot(input int idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser followed by a single-cycle edge detector.
// RISE=1 flags 0->1 transitions; RISE=0 flags 1->0 transitions.
module edge_sync #(
    parameter int STAGES = 2,
    parameter bit RISE   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    // Reset to the idle level so that releasing reset never fakes an edge.
    localparam logic IDLE = RISE ? 1'b0 : 1'b1;

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{IDLE}};
            prev  <= IDLE;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign pulse = RISE ? (chain[STAGES-1] & ~prev) : (~chain[STAGES-1] & prev);

endmodule

// File: rtl/timing_sequencer.sv
// One-hot T-state sequencer: opcode-fetch sync, RDY stalls, add-cycle repeats,
// interrupt hijack of the next opcode fetch, and set-overflow pin pulse.
module timing_sequencer
    import timing_pkg::*;
#(
    parameter int NUM_T       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             r_not_w,
    input  logic             last_cycle,
    input  logic             add_cycle,
    input  logic             nmi_req,
    input  logic             irq_req,
    input  logic             i_flag,
    input  logic             so_n,
    output logic [NUM_T-1:0] timing,
    output logic             sync,
    output logic             force_brk,
    output logic [1:0]       vec_sel,
    output logic             suppress_wr,
    output logic             stall,
    output logic             extra,
    output logic             set_v,
    output logic             seq_err
);

    logic nmi_rise;
    logic so_fall;
    logic nmi_pend;
    logic repeat_now;
    logic end_instr;

    edge_sync #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_nmi_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (nmi_req),
        .pulse (nmi_rise)
    );

    edge_sync #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_so_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (so_n),
        .pulse (so_fall)
    );

    // RDY only freezes read cycles; a write in flight always completes.
    assign stall      = ~rdy & r_not_w;
    assign sync       = timing[T1_IDX];
    assign repeat_now = add_cycle & ~extra;
    // Running off the top T-state is treated as an instruction end.
    assign end_instr  = last_cycle | (~repeat_now & timing[NUM_T-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timing      <= NUM_T'(1);
            force_brk   <= 1'b1;
            vec_sel     <= VEC_RES;
            suppress_wr <= 1'b1;
            extra       <= 1'b0;
            set_v       <= 1'b0;
            seq_err     <= 1'b0;
            nmi_pend    <= 1'b0;
        end else begin
            set_v <= so_fall;
            if (!stall) begin
                if (end_instr) begin
                    timing      <= NUM_T'(1);
                    extra       <= 1'b0;
                    suppress_wr <= 1'b0;
                    if (!last_cycle) begin
                        seq_err <= 1'b1;
                    end
                    if (nmi_pend) begin
                        force_brk <= 1'b1;
                        vec_sel   <= VEC_NMI;
                        nmi_pend  <= 1'b0;
                    end else if (irq_req && !i_flag) begin
                        force_brk <= 1'b1;
                        vec_sel   <= VEC_IRQ;
                    end else begin
                        force_brk <= 1'b0;
                        vec_sel   <= VEC_IRQ;
                    end
                end else if (repeat_now) begin
                    extra <= 1'b1;
                end else begin
                    timing <= timing << 1;
                    extra  <= 1'b0;
                end
            end
            // A new NMI edge wins over a same-cycle service of the old one.
            if (nmi_rise) begin
                nmi_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: per-cycle T-state expectations go through
// a queue and are compared after each clock; side outputs are checked inline.
module tb_timing_sequencer;

    localparam int NUM_T       = 8;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             r_not_w;
    logic             last_cycle;
    logic             add_cycle;
    logic             nmi_req;
    logic             irq_req;
    logic             i_flag;
    logic             so_n;
    logic [NUM_T-1:0] timing;
    logic             sync;
    logic             force_brk;
    logic [1:0]       vec_sel;
    logic             suppress_wr;
    logic             stall;
    logic             extra;
    logic             set_v;
    logic             seq_err;

    logic [NUM_T-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    timing_sequencer #(.NUM_T(NUM_T), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .r_not_w     (r_not_w),
        .last_cycle  (last_cycle),
        .add_cycle   (add_cycle),
        .nmi_req     (nmi_req),
        .irq_req     (irq_req),
        .i_flag      (i_flag),
        .so_n        (so_n),
        .timing      (timing),
        .sync        (sync),
        .force_brk   (force_brk),
        .vec_sel     (vec_sel),
        .suppress_wr (suppress_wr),
        .stall       (stall),
        .extra       (extra),
        .set_v       (set_v),
        .seq_err     (seq_err)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push the expected T-state, clock once, then pop and compare.
    task automatic tick(input logic [NUM_T-1:0] exp_t);
        logic [NUM_T-1:0] e;
        exp_q.push_back(exp_t);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("timing", 32'(timing), 32'(e));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; r_not_w = 1'b1; last_cycle = 1'b0; add_cycle = 1'b0;
        nmi_req = 1'b0; irq_req = 1'b0; i_flag = 1'b1; so_n = 1'b1;
        #3;
        chk("rst_timing", 32'(timing), 32'h01);
        chk("rst_sync", 32'(sync), 32'd1);
        chk("rst_force_brk", 32'(force_brk), 32'd1);
        chk("rst_vec_sel", 32'(vec_sel), 32'd2);
        chk("rst_suppress_wr", 32'(suppress_wr), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_extra", 32'(extra), 32'd0);
        chk("rst_set_v", 32'(set_v), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset sequence as a 2-cycle op
        tick(8'h02);
        chk("t2_sync", 32'(sync), 32'd0);
        chk("t2_suppress_wr", 32'(suppress_wr), 32'd1);
        chk("t2_vec_sel", 32'(vec_sel), 32'd2);
        last_cycle = 1'b1;
        tick(8'h01);
        chk("end1_sync", 32'(sync), 32'd1);
        chk("end1_suppress_wr", 32'(suppress_wr), 32'd0);
        chk("end1_vec_sel", 32'(vec_sel), 32'd0);
        chk("end1_force_brk", 32'(force_brk), 32'd0);
        last_cycle = 1'b0;
        tick(8'h02);
        tick(8'h04);

        // RDY stall on read at T3
        rdy = 1'b0;
        #1;
        chk("stall_read", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(8'h04);
            chk("stall_hold", 32'(stall), 32'd1);
        end
        r_not_w = 1'b0;
        #1;
        chk("stall_write", 32'(stall), 32'd0);
        tick(8'h08);
        rdy = 1'b1; r_not_w = 1'b1;

        // add_cycle held T4..T5: exactly one repeat
        add_cycle = 1'b1;
        tick(8'h08);
        chk("add_extra1", 32'(extra), 32'd1);
        tick(8'h10);
        chk("add_extra0", 32'(extra), 32'd0);
        add_cycle = 1'b0;
        last_cycle = 1'b1;
        tick(8'h01);
        last_cycle = 1'b0;

        // NMI pulse mid-instruction with IRQ also pending
        tick(8'h02);
        nmi_req = 1'b1; irq_req = 1'b1; i_flag = 1'b0;
        tick(8'h04);
        nmi_req = 1'b0;
        tick(8'h08);
        tick(8'h10);
        last_cycle = 1'b1;
        tick(8'h01);
        chk("nmi_force_brk", 32'(force_brk), 32'd1);
        chk("nmi_vec_sel", 32'(vec_sel), 32'd1);
        last_cycle = 1'b0;
        tick(8'h02);
        chk("nmi_vec_hold", 32'(vec_sel), 32'd1);
        last_cycle = 1'b1;
        tick(8'h01);
        chk("irq_force_brk", 32'(force_brk), 32'd1);
        chk("irq_vec_sel", 32'(vec_sel), 32'd0);

        // IRQ masked
        i_flag = 1'b1;
        last_cycle = 1'b0;
        tick(8'h02);
        last_cycle = 1'b1;
        tick(8'h01);
        chk("masked_force_brk", 32'(force_brk), 32'd0);

        // NMI edge arriving while stalled is still latched
        last_cycle = 1'b0;
        tick(8'h02);
        rdy = 1'b0; nmi_req = 1'b1;
        tick(8'h02);
        nmi_req = 1'b0;
        tick(8'h02);
        tick(8'h02);
        tick(8'h02);
        chk("nmi_stall_force_hold", 32'(force_brk), 32'd0);
        rdy = 1'b1; last_cycle = 1'b1;
        tick(8'h01);
        chk("nmi_stall_force_brk", 32'(force_brk), 32'd1);
        chk("nmi_stall_vec_sel", 32'(vec_sel), 32'd1);

        // Run past top T-state
        last_cycle = 1'b0;
        for (int k = 1; k < NUM_T; k++) begin
            tick(NUM_T'(1) << k);
        end
        chk("top_seq_err0", 32'(seq_err), 32'd0);
        tick(8'h01);
        chk("wrap_seq_err", 32'(seq_err), 32'd1);
        chk("wrap_force_brk", 32'(force_brk), 32'd0);
        tick(8'h02);
        chk("sticky_seq_err", 32'(seq_err), 32'd1);

        // SO falling edge -> single set_v pulse SYNC_STAGES+1 cycles later
        so_n = 1'b0;
        tick(8'h04);
        chk("setv_c1", 32'(set_v), 32'd0);
        tick(8'h08);
        chk("setv_c2", 32'(set_v), 32'd0);
        tick(8'h10);
        chk("setv_c3", 32'(set_v), 32'd1);
        tick(8'h20);
        chk("setv_c4", 32'(set_v), 32'd0);

        // Reset mid-instruction
        rst = 1'b1;
        #1;
        chk("midrst_timing", 32'(timing), 32'h01);
        chk("midrst_vec_sel", 32'(vec_sel), 32'd2);
        chk("midrst_force_brk", 32'(force_brk), 32'd1);
        chk("midrst_suppress_wr", 32'(suppress_wr), 32'd1);
        chk("midrst_seq_err", 32'(seq_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
